// File: rtl/alu381_pkg.sv
// ============================================================================
// Module      : alu381_pkg
// Description : Op codes, FSM state encoding and carry-in lookup shared by the
//               74381-style nibble-serial ALU.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package alu381_pkg;

    localparam int C_SLICE_W = 4;

    localparam logic [2:0] OP_CLR = 3'b000;
    localparam logic [2:0] OP_BMA = 3'b001;
    localparam logic [2:0] OP_AMB = 3'b010;
    localparam logic [2:0] OP_ADD = 3'b011;
    localparam logic [2:0] OP_XOR = 3'b100;
    localparam logic [2:0] OP_OR  = 3'b101;
    localparam logic [2:0] OP_AND = 3'b110;
    localparam logic [2:0] OP_SET = 3'b111;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Subtracts are A + ~B + 1, so they enter the LSB nibble with carry set.
    function automatic logic cin0_of(input logic [2:0] op);
        return (op == OP_BMA) || (op == OP_AMB);
    endfunction

endpackage

`default_nettype wire

// File: rtl/alu381_slice.sv
// ============================================================================
// Module      : alu381_slice
// Description : Combinational 4-bit 74381-style slice producing F, group
//               generate/propagate and ripple carry out.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module alu381_slice
    import alu381_pkg::*;
(
    input  logic [C_SLICE_W-1:0] a,
    input  logic [C_SLICE_W-1:0] b,
    input  logic [2:0]           s,
    input  logic                 cin,
    output logic [C_SLICE_W-1:0] f,
    output logic                 g,
    output logic                 p,
    output logic                 cout
);

    logic [C_SLICE_W-1:0] w_x;
    logic [C_SLICE_W-1:0] w_y;
    logic [C_SLICE_W:0]   w_xy;
    logic [C_SLICE_W:0]   w_sum;
    logic                 w_arith;

    always_comb begin
        w_x     = a;
        w_y     = b;
        w_arith = 1'b0;
        case (s)
            OP_BMA:  begin w_x = ~a; w_arith = 1'b1; end
            OP_AMB:  begin w_y = ~b; w_arith = 1'b1; end
            OP_ADD:  w_arith = 1'b1;
            default: w_arith = 1'b0;
        endcase
    end

    assign w_xy  = {1'b0, w_x} + {1'b0, w_y};
    assign w_sum = w_xy + {{C_SLICE_W{1'b0}}, cin};

    // Logic ops never generate or propagate, so their carry chain stays 0.
    assign g    = w_arith & w_xy[C_SLICE_W];
    assign p    = w_arith & (&(w_x ^ w_y));
    assign cout = g | (p & cin);

    always_comb begin
        f = '0;
        case (s)
            OP_BMA, OP_AMB, OP_ADD: f = w_sum[C_SLICE_W-1:0];
            OP_XOR:  f = a ^ b;
            OP_OR:   f = a | b;
            OP_AND:  f = a & b;
            OP_SET:  f = '1;
            default: f = '0;
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/alu381_serial_seq.sv
// ============================================================================
// Module      : alu381_serial_seq
// Description : Runs one 74381 slice over WIDTH-bit operands, one nibble per
//               clock, LSB first. Optional macro ALU381_EARLY_DONE_EN lets the
//               constant ops (clear/set) skip the serial pass.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module alu381_serial_seq
    import alu381_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int SLICE = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [WIDTH-1:0] req_a,
    input  logic [WIDTH-1:0] req_b,
    input  logic [2:0]       req_s,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_f,
    output logic             rsp_cout,
    output logic             rsp_ovf,
    output logic             rsp_zero
);

    localparam int NSLICE = WIDTH / SLICE;
    localparam int IDX_W  = (NSLICE > 1) ? $clog2(NSLICE) : 1;
    localparam logic [IDX_W-1:0] C_LAST_IDX = IDX_W'(NSLICE - 1);

    state_t           r_state;
    state_t           w_state_next;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [2:0]       r_s;
    logic [IDX_W-1:0] r_idx;
    logic             r_carry;
    logic [WIDTH-1:0] r_f;
    logic             r_cout;
    logic             r_ovf;
    logic             r_zero;

    logic [SLICE-1:0] w_nib_a;
    logic [SLICE-1:0] w_nib_b;
    logic [SLICE-1:0] w_nib_f;
    logic             w_g;
    logic             w_p;
    logic             w_cout;
    logic [WIDTH-1:0] w_f_next;
    logic             w_accept;
    logic             w_last;
    logic             w_early;
    logic             w_ovf;

`ifdef ALU381_EARLY_DONE_EN
    assign w_early = (req_s == OP_CLR) || (req_s == OP_SET);
`else
    assign w_early = 1'b0;
`endif

    assign w_accept = (r_state == ST_IDLE) && req_valid;
    assign w_last   = (r_idx == C_LAST_IDX);
    assign w_nib_a  = r_a[r_idx*SLICE +: SLICE];
    assign w_nib_b  = r_b[r_idx*SLICE +: SLICE];

    alu381_slice u_slice (
        .a    (w_nib_a),
        .b    (w_nib_b),
        .s    (r_s),
        .cin  (r_carry),
        .f    (w_nib_f),
        .g    (w_g),
        .p    (w_p),
        .cout (w_cout)
    );

    always_comb begin
        w_f_next = r_f;
        w_f_next[r_idx*SLICE +: SLICE] = w_nib_f;
    end

    always_comb begin
        w_ovf = 1'b0;
        case (r_s)
            OP_ADD: w_ovf = (r_a[WIDTH-1] == r_b[WIDTH-1]) && (w_f_next[WIDTH-1] != r_a[WIDTH-1]);
            OP_AMB: w_ovf = (r_a[WIDTH-1] != r_b[WIDTH-1]) && (w_f_next[WIDTH-1] != r_a[WIDTH-1]);
            OP_BMA: w_ovf = (r_a[WIDTH-1] != r_b[WIDTH-1]) && (w_f_next[WIDTH-1] != r_b[WIDTH-1]);
            default: w_ovf = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) r_state <= ST_IDLE;
        else     r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        req_ready    = 1'b0;
        rsp_valid    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                req_ready = 1'b1;
                if (req_valid) w_state_next = w_early ? ST_DONE : ST_RUN;
            end
            ST_RUN: begin
                if (w_last) w_state_next = ST_DONE;
            end
            ST_DONE: begin
                rsp_valid = 1'b1;
                if (rsp_ready) w_state_next = ST_IDLE;
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_a     <= '0;
            r_b     <= '0;
            r_s     <= OP_CLR;
            r_idx   <= '0;
            r_carry <= 1'b0;
            r_f     <= '0;
            r_cout  <= 1'b0;
            r_ovf   <= 1'b0;
            r_zero  <= 1'b0;
        end else if (w_accept) begin
            r_a     <= req_a;
            r_b     <= req_b;
            r_s     <= req_s;
            r_idx   <= '0;
            r_carry <= cin0_of(req_s);
            r_f     <= (w_early && (req_s == OP_SET)) ? '1 : '0;
            r_cout  <= 1'b0;
            r_ovf   <= 1'b0;
            r_zero  <= w_early && (req_s == OP_CLR);
        end else if (r_state == ST_RUN) begin
            r_f     <= w_f_next;
            r_carry <= w_cout;
            r_idx   <= r_idx + 1'b1;
            if (w_last) begin
                // Final carry taken in lookahead form; equals the slice ripple cout.
                r_cout <= w_g | (w_p & r_carry);
                r_ovf  <= w_ovf;
                r_zero <= (w_f_next == '0);
            end
        end
    end

    assign rsp_f    = r_f;
    assign rsp_cout = r_cout;
    assign rsp_ovf  = r_ovf;
    assign rsp_zero = r_zero;

endmodule

`default_nettype wire

// File: tb/tb_alu381_serial_seq.sv
// ============================================================================
// Module      : tb_alu381_serial_seq
// Description : Self-checking bench for alu381_serial_seq against a plain
//               arithmetic reference model. Honours ALU381_EARLY_DONE_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_alu381_serial_seq;

    localparam int W  = 32;
    localparam int NS = 8;
    localparam longint SMAX = 64'sd2147483647;
    localparam longint SMIN = -64'sd2147483648;
`ifdef ALU381_EARLY_DONE_EN
    localparam bit EARLY = 1'b1;
`else
    localparam bit EARLY = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         req_valid = 1'b0;
    logic         req_ready;
    logic [W-1:0] req_a = '0;
    logic [W-1:0] req_b = '0;
    logic [2:0]   req_s = '0;
    logic         rsp_valid;
    logic         rsp_ready = 1'b0;
    logic [W-1:0] rsp_f;
    logic         rsp_cout;
    logic         rsp_ovf;
    logic         rsp_zero;

    int errors = 0;
    int checks = 0;

    alu381_serial_seq #(.WIDTH(W), .SLICE(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .req_s     (req_s),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_f     (rsp_f),
        .rsp_cout  (rsp_cout),
        .rsp_ovf   (rsp_ovf),
        .rsp_zero  (rsp_zero)
    );

    always #5 clk = ~clk;

    // Reference: whole-word arithmetic; signed overflow from 64-bit results.
    function automatic void model(input logic [W-1:0] a, input logic [W-1:0] b, input logic [2:0] s,
                                  output logic [W-1:0] f, output logic c, output logic o);
        longint sa, sb, r;
        logic [W:0] sum;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        f = '0; c = 1'b0; o = 1'b0;
        case (s)
            3'd1: begin f = b - a; c = (b >= a); r = sb - sa; o = (r > SMAX) || (r < SMIN); end
            3'd2: begin f = a - b; c = (a >= b); r = sa - sb; o = (r > SMAX) || (r < SMIN); end
            3'd3: begin
                sum = {1'b0, a} + {1'b0, b};
                f = sum[W-1:0]; c = sum[W];
                r = sa + sb; o = (r > SMAX) || (r < SMIN);
            end
            3'd4: f = a ^ b;
            3'd5: f = a | b;
            3'd6: f = a & b;
            3'd7: f = '1;
            default: f = '0;
        endcase
    endfunction

    // Edges after the accept edge until rsp_valid is seen.
    function automatic int exp_lat(input logic [2:0] s);
        return (EARLY && (s == 3'd0 || s == 3'd7)) ? 0 : NS;
    endfunction

    function automatic logic [W-1:0] pick();
        case ($urandom_range(0, 5))
            0: return '0;
            1: return '1;
            2: return 32'h8000_0000;
            3: return 32'h7FFF_FFFF;
            default: return $urandom;
        endcase
    endfunction

    // Called #1 after an edge with the DUT idle; returns #1 after rsp_valid rises.
    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic [2:0] s,
                          output int lat, output bit timed_out, output bit was_ready);
        was_ready = req_ready;
        req_a = a; req_b = b; req_s = s; req_valid = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        req_a = $urandom; req_b = $urandom; req_s = 3'($urandom);
        lat = 0; timed_out = 1'b0;
        while (!rsp_valid) begin
            if (lat >= 40) begin timed_out = 1'b1; break; end
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic consume();
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({req_ready, rsp_valid} !== 2'b10) begin
            errors++; $display("FAIL reset_handshake: got ready/valid=%b want 10", {req_ready, rsp_valid});
        end
        checks++;
        if ({rsp_f, rsp_cout, rsp_ovf, rsp_zero} !== {32'h0, 3'b000}) begin
            errors++; $display("FAIL reset_outputs: got f=%h c/o/z=%b want 0 000", rsp_f, {rsp_cout, rsp_ovf, rsp_zero});
        end
        rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_directed();
        logic [W-1:0] ta [7] = '{32'h7FFF_FFFF, 32'd5, 32'd5, 32'hF0F0_F0F0, 32'hFFFF_FFFF, 32'h1234_5678, 32'hDEAD_BEEF};
        logic [W-1:0] tb [7] = '{32'h1, 32'd7, 32'd7, 32'hFFFF_0000, 32'h1, 32'h0, 32'h5555_AAAA};
        logic [2:0]   ts [7] = '{3'd3, 3'd2, 3'd1, 3'd4, 3'd3, 3'd7, 3'd0};
        logic [W-1:0] tf [7] = '{32'h8000_0000, 32'hFFFF_FFFE, 32'h2, 32'h0F0F_F0F0, 32'h0, 32'hFFFF_FFFF, 32'h0};
        logic [2:0]   tc [7] = '{3'b010, 3'b000, 3'b100, 3'b000, 3'b101, 3'b000, 3'b001};
        int lat; bit to, rdy;
        for (int i = 0; i < 7; i++) begin
            run_op(ta[i], tb[i], ts[i], lat, to, rdy);
            checks++;
            if (to || !rdy || lat != exp_lat(ts[i])) begin
                errors++; $display("FAIL dir%0d_latency: got %0d (timeout=%0d ready=%0d) want %0d", i, lat, to, rdy, exp_lat(ts[i]));
            end
            checks++;
            if ({rsp_f, rsp_cout, rsp_ovf, rsp_zero} !== {tf[i], tc[i]}) begin
                errors++; $display("FAIL dir%0d_result: got f=%h c/o/z=%b want f=%h c/o/z=%b", i, rsp_f, {rsp_cout, rsp_ovf, rsp_zero}, tf[i], tc[i]);
            end
            consume();
        end
    endtask

    task automatic test_random();
        logic [W-1:0] a, b, ef; logic [2:0] s; logic ec, eo;
        int lat, hold; bit to, rdy;
        for (int n = 0; n < 40; n++) begin
            a = pick(); b = pick(); s = 3'($urandom_range(0, 7));
            model(a, b, s, ef, ec, eo);
            run_op(a, b, s, lat, to, rdy);
            checks++;
            if (to || !rdy || lat != exp_lat(s)) begin
                errors++; $display("FAIL rnd%0d_latency: got %0d (timeout=%0d ready=%0d) want %0d", n, lat, to, rdy, exp_lat(s));
            end
            hold = $urandom_range(0, 3);
            for (int k = 0; k <= hold; k++) begin
                checks++;
                if ({rsp_valid, rsp_f, rsp_cout, rsp_ovf, rsp_zero} !== {1'b1, ef, ec, eo, ef == '0}) begin
                    errors++; $display("FAIL rnd%0d_result: s=%0d a=%h b=%h got v=%b f=%h c/o/z=%b want f=%h c/o/z=%b",
                        n, s, a, b, rsp_valid, rsp_f, {rsp_cout, rsp_ovf, rsp_zero}, ef, {ec, eo, ef == '0});
                end
                if (k < hold) begin @(posedge clk); #1; end
            end
            consume();
        end
    endtask

    task automatic test_back_pressure();
        int lat; bit to, rdy;
        run_op(32'h0000_00FF, 32'h0000_0001, 3'd3, lat, to, rdy);
        checks++;
        if (to || !rsp_valid) begin errors++; $display("FAIL bp_valid: got valid=%b want 1", rsp_valid); end
        for (int k = 0; k < 5; k++) begin
            req_valid = 1'b1; req_a = $urandom; req_b = $urandom; req_s = 3'd2;
            @(posedge clk); #1;
            checks++;
            if ({rsp_valid, req_ready, rsp_f, rsp_cout, rsp_ovf, rsp_zero} !== {2'b10, 32'h100, 3'b000}) begin
                errors++; $display("FAIL bp_hold%0d: got v/r=%b f=%h c/o/z=%b want 10 f=00000100 000", k,
                    {rsp_valid, req_ready}, rsp_f, {rsp_cout, rsp_ovf, rsp_zero});
            end
        end
        req_valid = 1'b0;
        consume();
        checks++;
        if ({rsp_valid, req_ready} !== 2'b01) begin
            errors++; $display("FAIL bp_release: got v/r=%b want 01", {rsp_valid, req_ready});
        end
        run_op(32'd10, 32'd3, 3'd2, lat, to, rdy);
        checks++;
        if (to || !rdy || rsp_f !== 32'd7 || rsp_cout !== 1'b1) begin
            errors++; $display("FAIL bp_next: got f=%h c=%b (timeout=%0d) want f=00000007 c=1", rsp_f, rsp_cout, to);
        end
        consume();
    endtask

    task automatic test_reset_mid_op();
        bit seen = 1'b0;
        int lat; bit to, rdy;
        req_a = 32'h1111_1111; req_b = 32'h2222_2222; req_s = 3'd3; req_valid = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        repeat (3) begin @(posedge clk); #1; end
        rst = 1'b1;
        @(posedge clk); #1;
        checks++;
        if ({req_ready, rsp_valid, rsp_f, rsp_cout, rsp_ovf, rsp_zero} !== {2'b10, 32'h0, 3'b000}) begin
            errors++; $display("FAIL midrst_outputs: got r/v=%b f=%h c/o/z=%b want 10 0 000",
                {req_ready, rsp_valid}, rsp_f, {rsp_cout, rsp_ovf, rsp_zero});
        end
        rst = 1'b0;
        repeat (12) begin
            @(posedge clk); #1;
            if (rsp_valid) seen = 1'b1;
        end
        checks++;
        if (seen) begin errors++; $display("FAIL midrst_no_rsp: got response after reset want none"); end
        run_op(32'hFFFF_FFFF, 32'h0000_0001, 3'd3, lat, to, rdy);
        checks++;
        if (to || !rdy || {rsp_f, rsp_cout, rsp_zero} !== {32'h0, 2'b11}) begin
            errors++; $display("FAIL midrst_recover: got f=%h c/z=%b want 0 11", rsp_f, {rsp_cout, rsp_zero});
        end
        consume();
    endtask

    initial begin
        test_reset();
        test_directed();
        test_random();
        test_back_pressure();
        test_reset_mid_op();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

`default_nettype wire
